// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: mode encodings, default frame width, controller states and the
// sample-edge selection helper.
package spi_pkg;

    // Mode encodings as {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_FRAME_BITS_DEFAULT = 360;

    typedef enum logic [1:0] {
        StUnarmed,
        StIdle,
        StActive
    } spi_state_e;

    // The leading edge rises when CPOL=0; CPHA=0 samples on the leading edge.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_slave_sync_if.sv
// Pad-side SPI pins plus the parallel rx/tx handshake towards the register bank.
interface spi_slave_sync_if
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = SPI_FRAME_BITS_DEFAULT
) ();
    logic                  cs_n;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic [FRAME_BITS-1:0] tx_data;
    logic                  tx_taken;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  cs_n, sclk, mosi, tx_data,
        output miso, tx_taken, rx_data, rx_valid, frame_err, busy
    );

    modport master (
        output cs_n, sclk, mosi, tx_data,
        input  miso, tx_taken, rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for edge detection; o_edge marks any change of o_sync.
module spi_sync_edge #(
    parameter bit IDLE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_sync,
    output logic o_edge
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= IDLE;
            r_sync <= IDLE;
            r_prev <= IDLE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_edge = r_sync ^ r_prev;
endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave oversampled on clk: frames land on rx_data with a one-cycle rx_valid, replies are
// captured from tx_data with a one-cycle tx_taken, and early deselects raise frame_err.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int unsigned FRAME_BITS = SPI_FRAME_BITS_DEFAULT,
    parameter bit          CPOL       = 1'b1,
    parameter bit          CPHA       = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    spi_slave_sync_if.slave bus
);
    localparam int unsigned      CNT_W       = $clog2(FRAME_BITS + 1);
    localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(FRAME_BITS);

    logic w_sclk_sync, w_sclk_edge, w_cs_sync, w_cs_edge;
    logic w_sample, w_shift, w_cs_fall, w_cs_rise;

    spi_sync_edge #(.IDLE(CPOL)) u_sclk_sync (
        .i_clk  (clk),
        .i_reset(reset),
        .i_d    (bus.sclk),
        .o_sync (w_sclk_sync),
        .o_edge (w_sclk_edge)
    );

    spi_sync_edge #(.IDLE(1'b1)) u_cs_sync (
        .i_clk  (clk),
        .i_reset(reset),
        .i_d    (bus.cs_n),
        .o_sync (w_cs_sync),
        .o_edge (w_cs_edge)
    );

    assign w_sample  = w_sclk_edge & (w_sclk_sync == SAMPLE_RISE);
    assign w_shift   = w_sclk_edge & (w_sclk_sync != SAMPLE_RISE);
    assign w_cs_fall = w_cs_edge & ~w_cs_sync;
    assign w_cs_rise = w_cs_edge & w_cs_sync;

    spi_state_e            r_state, w_state_d;
    logic [CNT_W-1:0]      r_cnt, w_cnt_d, w_cnt_inc;
    logic [FRAME_BITS-1:0] r_rx_shift, w_rx_shift_d;
    logic [FRAME_BITS-1:0] r_tx_shift, w_tx_shift_d;
    logic [FRAME_BITS-1:0] r_rx_data, w_rx_data_d;
    logic                  r_rx_valid, w_rx_valid_d;
    logic                  r_tx_taken, w_tx_taken_d;
    logic                  r_frame_err, w_frame_err_d;
    logic                  r_miso, w_miso_d;
    logic                  r_pend, w_pend_d;
    logic                  r_skip, w_skip_d;
    logic [1:0]            r_warm;
    logic                  r_mosi_meta, r_mosi_sync;

    // r_pend defers the back-to-back reload to the next shift edge, which is exactly when the
    // following frame's MSB must reach miso in either CPHA setting.
    always_comb begin
        w_state_d     = r_state;
        w_cnt_d       = r_cnt;
        w_cnt_inc     = r_cnt + CNT_W'(1);
        w_rx_shift_d  = r_rx_shift;
        w_tx_shift_d  = r_tx_shift;
        w_rx_data_d   = r_rx_data;
        w_rx_valid_d  = 1'b0;
        w_tx_taken_d  = 1'b0;
        w_frame_err_d = 1'b0;
        w_pend_d      = r_pend;
        w_skip_d      = r_skip;
        unique case (r_state)
            StUnarmed: begin
                // Only arm once the synchroniser holds a real pin value that is high.
                if (r_warm == 2'd2 && w_cs_sync) w_state_d = StIdle;
            end
            StIdle: begin
                if (w_cs_fall) begin
                    w_state_d    = StActive;
                    w_tx_shift_d = bus.tx_data;
                    w_tx_taken_d = 1'b1;
                    w_cnt_d      = '0;
                    w_pend_d     = 1'b0;
                    w_skip_d     = CPHA;
                end
            end
            StActive: begin
                if (w_sample) begin
                    w_rx_shift_d = (r_rx_shift << 1) | FRAME_BITS'(r_mosi_sync);
                    if (w_cnt_inc == CNT_LAST) begin
                        w_cnt_d      = '0;
                        w_rx_data_d  = w_rx_shift_d;
                        w_rx_valid_d = 1'b1;
                        w_pend_d     = 1'b1;
                    end else begin
                        w_cnt_d = w_cnt_inc;
                    end
                end else if (w_shift) begin
                    if (r_pend) begin
                        w_tx_shift_d = bus.tx_data;
                        w_tx_taken_d = 1'b1;
                        w_pend_d     = 1'b0;
                        w_skip_d     = 1'b0;
                    end else if (r_skip) begin
                        w_skip_d = 1'b0;
                    end else begin
                        w_tx_shift_d = (r_tx_shift << 1) | FRAME_BITS'(1);
                    end
                end
                if (w_cs_rise) begin
                    w_state_d = StIdle;
                    w_pend_d  = 1'b0;
                    w_skip_d  = 1'b0;
                    if (w_cnt_d != '0) begin
                        w_frame_err_d = 1'b1;
                        w_cnt_d       = '0;
                    end
                end
            end
            default: w_state_d = StUnarmed;
        endcase
        w_miso_d = (w_state_d == StActive) ? w_tx_shift_d[FRAME_BITS-1] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StUnarmed;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_taken  <= 1'b0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b1;
            r_pend      <= 1'b0;
            r_skip      <= 1'b0;
            r_warm      <= 2'd0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_rx_shift  <= w_rx_shift_d;
            r_tx_shift  <= w_tx_shift_d;
            r_rx_data   <= w_rx_data_d;
            r_rx_valid  <= w_rx_valid_d;
            r_tx_taken  <= w_tx_taken_d;
            r_frame_err <= w_frame_err_d;
            r_miso      <= w_miso_d;
            r_pend      <= w_pend_d;
            r_skip      <= w_skip_d;
            if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
            r_mosi_meta <= bus.mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign bus.miso      = r_miso;
    assign bus.tx_taken  = r_tx_taken;
    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = (r_state == StActive);
endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: four instances cover SPI modes 0-3 (mode 3 at 360 bits).
module tb_spi_slave_sync;
    localparam int             H      = 40;  // half sclk period = 4 clk periods
    localparam logic [3:0]     CPOL_T = 4'b1100;
    localparam logic [3:0]     CPHA_T = 4'b1010;
    localparam logic [359:0]   RX360  = {16'h1234, {42{8'h6C}}, 8'hAB};
    localparam logic [359:0]   TX360  = {45{8'hA5}};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   cs_n = 4'hF;
    logic [3:0]   sclk = CPOL_T;
    logic [3:0]   mosi = 4'h0;
    logic [3:0]   miso, rx_valid, tx_taken, frame_err, busy;
    logic [359:0] tx_data [4];
    logic [359:0] rx_data [4];
    int n_rxv [4];
    int n_txt [4];
    int n_err [4];
    int n_vec = 0;
    int n_bad = 0;

    spi_slave_sync_if #(.FRAME_BITS(16))  if0 ();
    spi_slave_sync_if #(.FRAME_BITS(16))  if1 ();
    spi_slave_sync_if #(.FRAME_BITS(16))  if2 ();
    spi_slave_sync_if #(.FRAME_BITS(360)) if3 ();

    assign if0.cs_n = cs_n[0]; assign if0.sclk = sclk[0]; assign if0.mosi = mosi[0];
    assign if1.cs_n = cs_n[1]; assign if1.sclk = sclk[1]; assign if1.mosi = mosi[1];
    assign if2.cs_n = cs_n[2]; assign if2.sclk = sclk[2]; assign if2.mosi = mosi[2];
    assign if3.cs_n = cs_n[3]; assign if3.sclk = sclk[3]; assign if3.mosi = mosi[3];
    assign if0.tx_data = tx_data[0][15:0];
    assign if1.tx_data = tx_data[1][15:0];
    assign if2.tx_data = tx_data[2][15:0];
    assign if3.tx_data = tx_data[3];
    assign miso      = {if3.miso, if2.miso, if1.miso, if0.miso};
    assign rx_valid  = {if3.rx_valid, if2.rx_valid, if1.rx_valid, if0.rx_valid};
    assign tx_taken  = {if3.tx_taken, if2.tx_taken, if1.tx_taken, if0.tx_taken};
    assign frame_err = {if3.frame_err, if2.frame_err, if1.frame_err, if0.frame_err};
    assign busy      = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign rx_data[0] = 360'(if0.rx_data);
    assign rx_data[1] = 360'(if1.rx_data);
    assign rx_data[2] = 360'(if2.rx_data);
    assign rx_data[3] = if3.rx_data;

    spi_slave_sync #(.FRAME_BITS(16), .CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .reset(reset), .bus(if0));
    spi_slave_sync #(.FRAME_BITS(16), .CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .clk(clk), .reset(reset), .bus(if1));
    spi_slave_sync #(.FRAME_BITS(16), .CPOL(1'b1), .CPHA(1'b0)) u_m2 (
        .clk(clk), .reset(reset), .bus(if2));
    spi_slave_sync #(.FRAME_BITS(360), .CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .reset(reset), .bus(if3));

    // Pulse counters: each count is the number of clk cycles the strobe was high.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rx_valid[k] === 1'b1) n_rxv[k] <= n_rxv[k] + 1;
            if (tx_taken[k] === 1'b1) n_txt[k] <= n_txt[k] + 1;
            if (frame_err[k] === 1'b1) n_err[k] <= n_err[k] + 1;
        end
    end

    // Master side: MSB first, miso captured on the master's sample edge.
    task automatic spi_bits(input int k, input int n, input logic [359:0] word,
                            output logic [359:0] got);
        got = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (CPHA_T[k] == 1'b0) begin
                mosi[k] = word[i];
                #H;
                sclk[k] = ~CPOL_T[k];
                got[i]  = miso[k];
                #H;
                sclk[k] = CPOL_T[k];
            end else begin
                sclk[k] = ~CPOL_T[k];
                mosi[k] = word[i];
                #H;
                sclk[k] = CPOL_T[k];
                got[i]  = miso[k];
                #H;
            end
        end
    endtask

    task automatic spi_frame(input int k, input int n, input logic [359:0] word,
                             output logic [359:0] got);
        cs_n[k] = 1'b0;
        #(2 * H);
        spi_bits(k, n, word, got);
        #H;
        cs_n[k] = 1'b1;
        #(2 * H);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (miso[k] !== 1'b1) begin n_bad++;
                $display("FAIL reset_miso[%0d]: got %b want 1", k, miso[k]); end
            n_vec++; if (rx_data[k] !== 360'h0) begin n_bad++;
                $display("FAIL reset_rx_data[%0d]: got %h want 0", k, rx_data[k]); end
            n_vec++; if (rx_valid[k] !== 1'b0) begin n_bad++;
                $display("FAIL reset_rx_valid[%0d]: got %b want 0", k, rx_valid[k]); end
            n_vec++; if (tx_taken[k] !== 1'b0) begin n_bad++;
                $display("FAIL reset_tx_taken[%0d]: got %b want 0", k, tx_taken[k]); end
            n_vec++; if (frame_err[k] !== 1'b0) begin n_bad++;
                $display("FAIL reset_frame_err[%0d]: got %b want 0", k, frame_err[k]); end
            n_vec++; if (busy[k] !== 1'b0) begin n_bad++;
                $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
        end
    endtask

    task automatic test_mode3_360();
        logic [359:0] got;
        int rxv0 = n_rxv[3];
        int txt0 = n_txt[3];
        tx_data[3] = TX360;
        spi_frame(3, 360, RX360, got);
        n_vec++; if (rx_data[3] !== RX360) begin n_bad++;
            $display("FAIL m3_rx_data: got %h want %h", rx_data[3], RX360); end
        n_vec++; if (got !== TX360) begin n_bad++;
            $display("FAIL m3_miso_stream: got %h want %h", got, TX360); end
        n_vec++; if (n_rxv[3] - rxv0 !== 1) begin n_bad++;
            $display("FAIL m3_rx_valid_count: got %0d want 1", n_rxv[3] - rxv0); end
        n_vec++; if (n_txt[3] - txt0 !== 1) begin n_bad++;
            $display("FAIL m3_tx_taken_count: got %0d want 1", n_txt[3] - txt0); end
    endtask

    task automatic test_modes_16();
        logic [359:0] got;
        for (int k = 0; k < 3; k++) begin
            int rxv0 = n_rxv[k];
            int err0 = n_err[k];
            tx_data[k] = 360'hC0DE;
            spi_frame(k, 16, 360'hBEEF, got);
            n_vec++; if (rx_data[k] !== 360'hBEEF) begin n_bad++;
                $display("FAIL mode%0d_rx_data: got %h want beef", k, rx_data[k][15:0]); end
            n_vec++; if (got !== 360'hC0DE) begin n_bad++;
                $display("FAIL mode%0d_miso: got %h want c0de", k, got[15:0]); end
            n_vec++; if (n_rxv[k] - rxv0 !== 1) begin n_bad++;
                $display("FAIL mode%0d_rx_valid_count: got %0d want 1", k, n_rxv[k] - rxv0); end
            n_vec++; if (n_err[k] - err0 !== 0) begin n_bad++;
                $display("FAIL mode%0d_frame_err: got %0d want 0", k, n_err[k] - err0); end
        end
    endtask

    task automatic test_frame_err();
        logic [359:0] got;
        int rxv0 = n_rxv[0];
        int err0 = n_err[0];
        cs_n[0] = 1'b0;
        #(2 * H);
        n_vec++; if (busy[0] !== 1'b1) begin n_bad++;
            $display("FAIL ferr_busy_selected: got %b want 1", busy[0]); end
        spi_bits(0, 7, 360'h55, got);
        #H;
        cs_n[0] = 1'b1;
        #(2 * H);
        n_vec++; if (n_err[0] - err0 !== 1) begin n_bad++;
            $display("FAIL ferr_pulse_cycles: got %0d want 1", n_err[0] - err0); end
        n_vec++; if (n_rxv[0] - rxv0 !== 0) begin n_bad++;
            $display("FAIL ferr_rx_valid: got %0d want 0", n_rxv[0] - rxv0); end
        n_vec++; if (rx_data[0] !== 360'hBEEF) begin n_bad++;
            $display("FAIL ferr_rx_kept: got %h want beef", rx_data[0][15:0]); end
        n_vec++; if (busy[0] !== 1'b0) begin n_bad++;
            $display("FAIL ferr_busy_released: got %b want 0", busy[0]); end
    endtask

    task automatic test_back_to_back();
        logic [359:0] got1, got2;
        int rxv0 = n_rxv[1];
        int txt0 = n_txt[1];
        int err0 = n_err[1];
        tx_data[1] = 360'hC0DE;
        cs_n[1] = 1'b0;
        #(2 * H);
        tx_data[1] = 360'h5A5A;
        spi_bits(1, 16, 360'h1234, got1);
        n_vec++; if (rx_data[1] !== 360'h1234) begin n_bad++;
            $display("FAIL b2b_rx_first: got %h want 1234", rx_data[1][15:0]); end
        spi_bits(1, 16, 360'hABCD, got2);
        #H;
        cs_n[1] = 1'b1;
        #(2 * H);
        n_vec++; if (got1 !== 360'hC0DE) begin n_bad++;
            $display("FAIL b2b_miso_first: got %h want c0de", got1[15:0]); end
        n_vec++; if (got2 !== 360'h5A5A) begin n_bad++;
            $display("FAIL b2b_miso_second: got %h want 5a5a", got2[15:0]); end
        n_vec++; if (rx_data[1] !== 360'hABCD) begin n_bad++;
            $display("FAIL b2b_rx_second: got %h want abcd", rx_data[1][15:0]); end
        n_vec++; if (n_rxv[1] - rxv0 !== 2) begin n_bad++;
            $display("FAIL b2b_rx_valid_count: got %0d want 2", n_rxv[1] - rxv0); end
        n_vec++; if (n_txt[1] - txt0 !== 2) begin n_bad++;
            $display("FAIL b2b_tx_taken_count: got %0d want 2", n_txt[1] - txt0); end
        n_vec++; if (n_err[1] - err0 !== 0) begin n_bad++;
            $display("FAIL b2b_frame_err: got %0d want 0", n_err[1] - err0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [359:0] got;
        int rxv0, txt0, err0;
        tx_data[0] = 360'hC0DE;
        cs_n[0] = 1'b0;
        #(2 * H);
        spi_bits(0, 5, 360'hF0F0, got);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rxv0 = n_rxv[0];
        txt0 = n_txt[0];
        err0 = n_err[0];
        spi_bits(0, 11, 360'h7FF, got);
        #H;
        n_vec++; if (busy[0] !== 1'b0) begin n_bad++;
            $display("FAIL rst_busy_unarmed: got %b want 0", busy[0]); end
        n_vec++; if (miso[0] !== 1'b1) begin n_bad++;
            $display("FAIL rst_miso_unarmed: got %b want 1", miso[0]); end
        cs_n[0] = 1'b1;
        #(2 * H);
        n_vec++; if (n_rxv[0] - rxv0 !== 0 || n_err[0] - err0 !== 0 || n_txt[0] - txt0 !== 0)
        begin n_bad++;
            $display("FAIL rst_no_pulses: got rxv=%0d err=%0d txt=%0d want 0/0/0",
                     n_rxv[0] - rxv0, n_err[0] - err0, n_txt[0] - txt0); end
        n_vec++; if (rx_data[0] !== 360'h0) begin n_bad++;
            $display("FAIL rst_rx_cleared: got %h want 0", rx_data[0][15:0]); end
        rxv0 = n_rxv[0];
        spi_frame(0, 16, 360'h1357, got);
        n_vec++; if (rx_data[0] !== 360'h1357) begin n_bad++;
            $display("FAIL rst_next_rx: got %h want 1357", rx_data[0][15:0]); end
        n_vec++; if (got !== 360'hC0DE) begin n_bad++;
            $display("FAIL rst_next_miso: got %h want c0de", got[15:0]); end
        n_vec++; if (n_rxv[0] - rxv0 !== 1) begin n_bad++;
            $display("FAIL rst_next_rx_valid: got %0d want 1", n_rxv[0] - rxv0); end
    endtask

    task automatic test_idle_sclk();
        logic [359:0] got;
        int rxv0 = n_rxv[0];
        int err0 = n_err[0];
        for (int i = 0; i < 20; i++) begin
            mosi[0] = 1'($urandom_range(1, 0));
            sclk[0] = ~sclk[0];
            #H;
            if (i == 9) begin
                n_vec++; if (miso[0] !== 1'b1 || busy[0] !== 1'b0) begin n_bad++;
                    $display("FAIL idle_miso_busy: got miso=%b busy=%b want 1/0", miso[0], busy[0]);
                end
            end
        end
        n_vec++; if (rx_data[0] !== 360'h1357) begin n_bad++;
            $display("FAIL idle_rx_kept: got %h want 1357", rx_data[0][15:0]); end
        n_vec++; if (n_rxv[0] - rxv0 !== 0 || n_err[0] - err0 !== 0) begin n_bad++;
            $display("FAIL idle_no_pulses: got rxv=%0d err=%0d want 0/0",
                     n_rxv[0] - rxv0, n_err[0] - err0); end
        // A clean frame afterwards shows the bit counter was left at zero.
        spi_frame(0, 16, 360'h0F1E, got);
        n_vec++; if (rx_data[0] !== 360'h0F1E || n_err[0] - err0 !== 0) begin n_bad++;
            $display("FAIL idle_next_frame: got %h err=%0d want 0f1e err=0",
                     rx_data[0][15:0], n_err[0] - err0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 4; k++) tx_data[k] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        repeat (8) @(negedge clk);
        test_mode3_360();
        test_modes_16();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_sclk();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
